// File: rtl/instr_encoder_if.sv
// Field-beat stream plus IMEM write port and status for instr_encoder.
// master = loader/bench side, slave = encoder side.
interface instr_encoder_if #(
    parameter int unsigned ADDR_W = 14,
    parameter int unsigned CNT_W  = 16
);
    logic              start;
    logic [ADDR_W-1:0] base_addr;
    logic              in_valid;
    logic              in_ready;
    logic [6:0]        opcode;
    logic [4:0]        rd;
    logic [2:0]        funct3;
    logic [4:0]        adr1;
    logic [4:0]        adr2;
    logic [6:0]        funct7;
    logic [31:0]       imm;
    logic              imem_ready;
    logic              imem_en;
    logic [3:0]        imem_wea;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_din;
    logic              err;
    logic [ADDR_W-1:0] err_addr;
    logic [CNT_W-1:0]  count;

    modport master (
        output start, base_addr, in_valid, opcode, rd, funct3, adr1, adr2, funct7, imm,
               imem_ready,
        input  in_ready, imem_en, imem_wea, imem_addr, imem_din, err, err_addr, count
    );

    modport slave (
        input  start, base_addr, in_valid, opcode, rd, funct3, adr1, adr2, funct7, imm,
               imem_ready,
        output in_ready, imem_en, imem_wea, imem_addr, imem_din, err, err_addr, count
    );
endinterface

// File: rtl/instr_encoder.sv
// Re-encodes decoded RV32I fields into instruction words and writes legal words
// sequentially into IMEM through a two-stage (encode/check, write) pipeline.
module instr_encoder #(
    parameter int unsigned ADDR_W = 14,
    parameter int unsigned CNT_W  = 16
) (
    input  logic            clk,
    input  logic            rst,
    instr_encoder_if.slave  bus
);
    localparam int unsigned XLEN = 32;

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;

    logic [XLEN-1:0]   imm;
    logic [31:0]       enc_word;
    logic              enc_err;
    logic              i_ok, b_ok, j_ok;

    logic              e_valid, e_err;
    logic [31:0]       e_word;
    logic              w_valid;
    logic [ADDR_W-1:0] addr;
    logic [ADDR_W-1:0] w_addr;
    logic [31:0]       w_word;
    logic              err_q;
    logic [ADDR_W-1:0] err_addr_q;
    logic [CNT_W-1:0]  count_q;

    logic              w_adv, e_load, e_good;

    assign imm    = bus.imm;
    assign w_adv  = !w_valid || bus.imem_ready;
    assign e_load = !e_valid || w_adv;
    assign e_good = e_valid && !e_err;

    // Sign-range checks: the discarded upper bits must be a pure sign extension.
    assign i_ok = (&imm[31:11]) || !(|imm[31:11]);
    assign b_ok = ((&imm[31:12]) || !(|imm[31:12])) && !imm[0];
    assign j_ok = ((&imm[31:20]) || !(|imm[31:20])) && !imm[0];

    always_comb begin
        enc_word = 32'h0;
        enc_err  = 1'b0;
        case (bus.opcode)
            OP_LUI, OP_AUIPC: begin
                enc_word = {imm[31:12], bus.rd, bus.opcode};
                enc_err  = |imm[11:0];
            end
            OP_JAL: begin
                enc_word = {imm[20], imm[10:1], imm[11], imm[19:12], bus.rd, bus.opcode};
                enc_err  = !j_ok;
            end
            OP_JALR, OP_LOAD: begin
                enc_word = {imm[11:0], bus.adr1, bus.funct3, bus.rd, bus.opcode};
                enc_err  = !i_ok;
            end
            OP_ITYPE: begin
                if (bus.funct3 == 3'b001 || bus.funct3 == 3'b101) begin
                    enc_word = {bus.funct7, imm[4:0], bus.adr1, bus.funct3, bus.rd, bus.opcode};
                    enc_err  = |imm[31:5];
                end else begin
                    enc_word = {imm[11:0], bus.adr1, bus.funct3, bus.rd, bus.opcode};
                    enc_err  = !i_ok;
                end
            end
            OP_BRANCH: begin
                enc_word = {imm[12], imm[10:5], bus.adr2, bus.adr1, bus.funct3,
                            imm[4:1], imm[11], bus.opcode};
                enc_err  = !b_ok;
            end
            OP_STORE: begin
                enc_word = {imm[11:5], bus.adr2, bus.adr1, bus.funct3, imm[4:0], bus.opcode};
                enc_err  = !i_ok;
            end
            OP_RTYPE: begin
                enc_word = {bus.funct7, bus.adr2, bus.adr1, bus.funct3, bus.rd, bus.opcode};
            end
            default: enc_err = 1'b1;
        endcase
    end

    // start outranks everything except reset; erroneous beats are retired from E without reaching W.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            e_valid    <= 1'b0;
            e_err      <= 1'b0;
            e_word     <= 32'h0;
            w_valid    <= 1'b0;
            w_addr     <= '0;
            w_word     <= 32'h0;
            addr       <= '0;
            err_q      <= 1'b0;
            err_addr_q <= '0;
            count_q    <= '0;
        end else if (bus.start) begin
            e_valid    <= 1'b0;
            w_valid    <= 1'b0;
            addr       <= bus.base_addr;
            err_q      <= 1'b0;
            err_addr_q <= '0;
            count_q    <= '0;
        end else begin
            if (e_load) begin
                e_valid <= bus.in_valid;
                e_err   <= enc_err;
                e_word  <= enc_word;
            end
            if (w_adv) begin
                w_valid <= e_good;
                if (e_good) begin
                    w_addr <= addr;
                    w_word <= e_word;
                    addr   <= ADDR_W'(addr + 1'b1);
                end
            end
            if (e_valid && e_err && w_adv) begin
                err_q <= 1'b1;
                if (!err_q) begin
                    err_addr_q <= addr;
                end
            end
            if (w_valid && bus.imem_ready && (count_q != {CNT_W{1'b1}})) begin
                count_q <= CNT_W'(count_q + 1'b1);
            end
        end
    end

    assign bus.in_ready  = !rst && !bus.start && e_load;
    assign bus.imem_en   = w_valid;
    assign bus.imem_wea  = {4{w_valid}};
    assign bus.imem_addr = w_addr;
    assign bus.imem_din  = w_word;
    assign bus.err       = err_q;
    assign bus.err_addr  = err_addr_q;
    assign bus.count     = count_q;
endmodule

// File: tb/tb_instr_encoder.sv
// Bench for instr_encoder: directed RV32I vectors plus randomized beats checked
// against a range/arithmetic reference model with a write scoreboard.
module tb_instr_encoder;
    localparam int unsigned ADDR_W = 14;
    localparam int unsigned CNT_W  = 16;

    localparam logic [6:0] LUI = 7'b0110111, AUIPC = 7'b0010111, JAL = 7'b1101111,
                           JALR = 7'b1100111, BRANCH = 7'b1100011, LOAD = 7'b0000011,
                           STORE = 7'b0100011, ITYPE = 7'b0010011, RTYPE = 7'b0110011;

    typedef struct {
        logic [6:0]  op;
        logic [4:0]  rd;
        logic [2:0]  f3;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [6:0]  f7;
        logic [31:0] imm;
    } beat_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    instr_encoder_if #(.ADDR_W(ADDR_W), .CNT_W(CNT_W)) bus ();
    instr_encoder #(.ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (.clk(clk), .rst(rst), .bus(bus));

    int checks = 0;
    int fails  = 0;
    int rdy_mode = 1;  // 0: hold low, 1: hold high, 2: random

    logic [45:0] exp_q[$];
    logic [45:0] obs_q[$];
    int unsigned addr_m;
    bit          err_m;
    int unsigned err_addr_m;
    int unsigned legal_m;

    always @(posedge clk)
        if (!rst && bus.imem_en && bus.imem_ready)
            obs_q.push_back({bus.imem_addr, bus.imem_din});

    function automatic bit model_legal(beat_t b);
        int s;
        s = $signed(b.imm);
        case (b.op)
            LUI, AUIPC:        return (b.imm % 4096) == 0;
            JAL:               return (s % 2 == 0) && s >= -1048576 && s < 1048576;
            BRANCH:            return (s % 2 == 0) && s >= -4096 && s < 4096;
            JALR, LOAD, STORE: return s >= -2048 && s < 2048;
            ITYPE:             return (b.f3 == 3'd1 || b.f3 == 3'd5) ? (b.imm < 32)
                                                                      : (s >= -2048 && s < 2048);
            RTYPE:             return 1'b1;
            default:           return 1'b0;
        endcase
    endfunction

    function automatic logic [31:0] model_encode(beat_t b);
        logic [31:0] v, base_i, rdf, r1, r2, f3;
        v    = b.imm;
        rdf  = 32'(b.rd) << 7;
        r1   = 32'(b.rs1) << 15;
        r2   = 32'(b.rs2) << 20;
        f3   = 32'(b.f3) << 12;
        base_i = r1 | f3 | rdf | 32'(b.op);
        case (b.op)
            LUI, AUIPC: return (v & 32'hFFFFF000) | rdf | 32'(b.op);
            JAL: return (((v >> 20) & 1) << 31) | (((v >> 1) & 32'h3FF) << 21) |
                        (((v >> 11) & 1) << 20) | (((v >> 12) & 32'hFF) << 12) | rdf | 32'(b.op);
            BRANCH: return (((v >> 12) & 1) << 31) | (((v >> 5) & 63) << 25) | r2 | r1 | f3 |
                           (((v >> 1) & 15) << 8) | (((v >> 11) & 1) << 7) | 32'(b.op);
            STORE: return (((v >> 5) & 127) << 25) | r2 | r1 | f3 | ((v & 31) << 7) | 32'(b.op);
            RTYPE: return (32'(b.f7) << 25) | r2 | base_i;
            ITYPE: if (b.f3 == 3'd1 || b.f3 == 3'd5)
                       return (32'(b.f7) << 25) | ((v & 31) << 20) | base_i;
                   else
                       return ((v & 32'hFFF) << 20) | base_i;
            default: return ((v & 32'hFFF) << 20) | base_i;
        endcase
    endfunction

    function automatic beat_t mk(logic [6:0] op, logic [4:0] rd, logic [2:0] f3, logic [4:0] rs1,
                                 logic [4:0] rs2, logic [6:0] f7, logic [31:0] imm);
        beat_t b;
        b.op = op; b.rd = rd; b.f3 = f3; b.rs1 = rs1; b.rs2 = rs2; b.f7 = f7; b.imm = imm;
        return b;
    endfunction

    function automatic beat_t rand_beat();
        beat_t       b;
        logic [12:0] t;
        logic [6:0]  ops [9];
        int          k;
        ops = '{LUI, AUIPC, JAL, JALR, BRANCH, LOAD, STORE, ITYPE, RTYPE};
        k = $urandom_range(0, 10);
        b.op  = (k < 9) ? ops[k] : 7'($urandom);
        if (k == 10) b.op = ITYPE;
        b.rd  = 5'($urandom); b.f3 = 3'($urandom); b.rs1 = 5'($urandom);
        b.rs2 = 5'($urandom); b.f7 = 7'($urandom);
        if ($urandom_range(0, 5) == 0) b.op = 7'($urandom);
        case ($urandom_range(0, 4))
            0: b.imm = $urandom;
            1: b.imm = 32'($urandom_range(0, 63)) - 32'd32;
            2: begin t = 13'($urandom); b.imm = {{19{t[12]}}, t}; end
            3: b.imm = {20'($urandom), 12'h0};
            default: b.imm = 32'($urandom_range(0, 31)) << 1;
        endcase
        return b;
    endfunction

    task automatic set_ready();
        case (rdy_mode)
            0:       bus.imem_ready = 1'b0;
            1:       bus.imem_ready = 1'b1;
            default: bus.imem_ready = ($urandom_range(0, 3) != 0);
        endcase
    endtask

    task automatic model_accept(beat_t b);
        if (model_legal(b)) begin
            exp_q.push_back({ADDR_W'(addr_m), model_encode(b)});
            addr_m = (addr_m + 1) % (1 << ADDR_W);
            legal_m++;
        end else if (!err_m) begin
            err_m = 1'b1;
            err_addr_m = addr_m;
        end
    endtask

    task automatic drive(beat_t b);
        bus.opcode = b.op; bus.rd = b.rd; bus.funct3 = b.f3; bus.adr1 = b.rs1;
        bus.adr2 = b.rs2; bus.funct7 = b.f7; bus.imm = b.imm;
    endtask

    task automatic send_beat(beat_t b);
        int n = 0;
        bit done = 0;
        @(negedge clk);
        drive(b);
        bus.in_valid = 1'b1;
        while (!done) begin
            set_ready();
            #1;
            if (bus.in_ready) begin
                @(posedge clk);
                done = 1;
                model_accept(b);
            end else if (n > 200) begin
                checks++; fails++;
                $display("FAIL accept_timeout: beat op=%b not accepted within %0d cycles", b.op, n);
                done = 1;
            end else begin
                n++;
                @(negedge clk);
            end
        end
        #1 bus.in_valid = 1'b0;
    endtask

    task automatic wait_obs(input int n, output bit ok);
        int k = 0;
        while (obs_q.size() < n && k < 100) begin
            @(negedge clk); set_ready(); k++;
        end
        ok = (obs_q.size() >= n);
    endtask

    task automatic do_start(logic [ADDR_W-1:0] base);
        @(negedge clk);
        bus.base_addr = base;
        bus.start = 1'b1;
        #1;
        checks++;
        if (bus.in_ready !== 1'b0) begin
            fails++; $display("FAIL start_in_ready: got %b expected 0", bus.in_ready);
        end
        @(posedge clk);
        #1 bus.start = 1'b0;
        exp_q.delete(); obs_q.delete();
        addr_m = base; err_m = 0; err_addr_m = 0; legal_m = 0;
    endtask

    // Wait for all expected words, then compare scoreboard, count and error state.
    task automatic drain(string name);
        int k = 0;
        while (obs_q.size() < exp_q.size() && k < 400) begin
            @(negedge clk); set_ready(); k++;
        end
        rdy_mode = 1;
        repeat (3) begin @(negedge clk); set_ready(); end
        checks++;
        if (obs_q.size() != exp_q.size()) begin
            fails++; $display("FAIL %s_nwrites: got %0d expected %0d", name, obs_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            checks++;
            if (obs_q[i] !== exp_q[i]) begin
                fails++;
                $display("FAIL %s_write%0d: got addr=%h din=%h expected addr=%h din=%h", name, i,
                         obs_q[i][45:32], obs_q[i][31:0], exp_q[i][45:32], exp_q[i][31:0]);
            end
        end
        checks++;
        if (bus.count !== CNT_W'(legal_m)) begin
            fails++; $display("FAIL %s_count: got %0d expected %0d", name, bus.count, legal_m);
        end
        checks++;
        if (bus.err !== err_m || (err_m && bus.err_addr !== ADDR_W'(err_addr_m))) begin
            fails++;
            $display("FAIL %s_err: got err=%b addr=%h expected err=%b addr=%h", name, bus.err,
                     bus.err_addr, err_m, err_addr_m);
        end
        exp_q.delete(); obs_q.delete();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.start = 0; bus.base_addr = '0; bus.in_valid = 0; bus.imem_ready = 1;
        drive(mk(7'h0, 0, 0, 0, 0, 0, 0));
        repeat (2) @(negedge clk);
        checks++;
        if (bus.in_ready !== 1'b0 || bus.imem_en !== 1'b0 || bus.imem_wea !== 4'h0 ||
            bus.imem_addr !== '0 || bus.imem_din !== 32'h0 || bus.err !== 1'b0 ||
            bus.err_addr !== '0 || bus.count !== '0) begin
            fails++;
            $display("FAIL reset_state: got rdy=%b en=%b wea=%h addr=%h din=%h err=%b ea=%h cnt=%0d expected all 0",
                     bus.in_ready, bus.imem_en, bus.imem_wea, bus.imem_addr, bus.imem_din,
                     bus.err, bus.err_addr, bus.count);
        end
        rst = 1'b0;
        #1;
        checks++;
        if (bus.in_ready !== 1'b1) begin
            fails++; $display("FAIL reset_release_ready: got %b expected 1", bus.in_ready);
        end
    endtask

    task automatic test_addi();
        do_start(14'h10);
        rdy_mode = 1;
        send_beat(mk(ITYPE, 5'd1, 3'd0, 5'd0, 5'd0, 7'd0, 32'd5));
        @(negedge clk);
        checks++;
        if (bus.imem_en !== 1'b0) begin
            fails++; $display("FAIL addi_early: imem_en got %b expected 0 one cycle after accept", bus.imem_en);
        end
        @(negedge clk);
        checks++;
        if (bus.imem_en !== 1'b1 || bus.imem_wea !== 4'hF || bus.imem_addr !== 14'h10 ||
            bus.imem_din !== 32'h00500093) begin
            fails++;
            $display("FAIL addi_write: got en=%b wea=%h addr=%h din=%h expected 1 f 0010 00500093",
                     bus.imem_en, bus.imem_wea, bus.imem_addr, bus.imem_din);
        end
        drain("addi");
        legal_m = 1;  // count persists across the next directed tests (no start)
    endtask

    task automatic test_sequence();
        logic [45:0] want [3];
        bit ok;
        addr_m = 14'h11;
        want = '{{14'h11, 32'h12345137}, {14'h12, 32'h00512423}, {14'h13, 32'hFE208EE3}};
        send_beat(mk(LUI, 5'd2, 3'd0, 5'd0, 5'd0, 7'd0, 32'h12345000));
        send_beat(mk(STORE, 5'd0, 3'd2, 5'd2, 5'd5, 7'd0, 32'd8));
        send_beat(mk(BRANCH, 5'd0, 3'd0, 5'd1, 5'd2, 7'd0, 32'hFFFFFFFC));
        wait_obs(3, ok);
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (!ok || obs_q[i] !== want[i]) begin
                fails++;
                $display("FAIL seq_word%0d: got %h expected %h", i, ok ? obs_q[i] : 46'h0, want[i]);
            end
        end
        drain("seq");
    endtask

    task automatic test_shift();
        bit ok;
        send_beat(mk(ITYPE, 5'd3, 3'd5, 5'd4, 5'd0, 7'b0100000, 32'd3));
        wait_obs(1, ok);
        checks++;
        if (!ok || obs_q[0] !== {14'h14, 32'h40325193}) begin
            fails++; $display("FAIL srai: got %h expected %h", ok ? obs_q[0] : 46'h0, {14'h14, 32'h40325193});
        end
        drain("shift");
    endtask

    task automatic test_error();
        bit ok;
        send_beat(mk(JAL, 5'd1, 3'd0, 5'd0, 5'd0, 7'd0, 32'h3));
        repeat (4) @(negedge clk);
        checks++;
        if (bus.err !== 1'b1 || bus.err_addr !== 14'h15 || obs_q.size() != 0) begin
            fails++;
            $display("FAIL jal_err: got err=%b err_addr=%h writes=%0d expected 1 0015 0",
                     bus.err, bus.err_addr, obs_q.size());
        end
        send_beat(mk(ITYPE, 5'd1, 3'd0, 5'd0, 5'd0, 7'd0, 32'd5));
        wait_obs(1, ok);
        checks++;
        if (!ok || obs_q[0] !== {14'h15, 32'h00500093}) begin
            fails++; $display("FAIL err_next: got %h expected %h", ok ? obs_q[0] : 46'h0, {14'h15, 32'h00500093});
        end
        drain("error");
    endtask

    task automatic test_stall();
        beat_t b3;
        do_start(14'h20);
        rdy_mode = 0;
        send_beat(mk(ITYPE, 5'd1, 3'd0, 5'd0, 5'd0, 7'd0, 32'd5));
        send_beat(mk(RTYPE, 5'd7, 3'd0, 5'd1, 5'd2, 7'd0, 32'd0));
        b3 = mk(STORE, 5'd0, 3'd2, 5'd2, 5'd5, 7'd0, 32'd8);
        @(negedge clk);
        drive(b3);
        bus.in_valid = 1'b1;
        for (int c = 0; c < 5; c++) begin
            #1;
            checks++;
            if (bus.in_ready !== 1'b0 || bus.imem_en !== 1'b1 || bus.imem_addr !== 14'h20 ||
                bus.imem_din !== 32'h00500093) begin
                fails++;
                $display("FAIL stall_hold%0d: got rdy=%b en=%b addr=%h din=%h expected 0 1 0020 00500093",
                         c, bus.in_ready, bus.imem_en, bus.imem_addr, bus.imem_din);
            end
            @(negedge clk);
        end
        bus.in_valid = 1'b0;
        rdy_mode = 1;
        send_beat(b3);
        drain("stall");
        checks++;
        if (bus.count !== 16'd3) begin
            fails++; $display("FAIL stall_count: got %0d expected 3", bus.count);
        end
    endtask

    task automatic test_wrap_and_start();
        bit ok;
        do_start(14'h3FFF);
        rdy_mode = 1;
        send_beat(mk(ITYPE, 5'd1, 3'd0, 5'd0, 5'd0, 7'd0, 32'd5));
        send_beat(mk(ITYPE, 5'd2, 3'd0, 5'd1, 5'd0, 7'd0, 32'hFFFFF800));
        wait_obs(2, ok);
        checks++;
        if (!ok || obs_q[0][45:32] !== 14'h3FFF || obs_q[1][45:32] !== 14'h0000) begin
            fails++;
            $display("FAIL wrap_addr: got %h,%h expected 3fff,0000",
                     ok ? obs_q[0][45:32] : 14'h0, ok ? obs_q[1][45:32] : 14'h0);
        end
        drain("wrap");
        rdy_mode = 0;
        send_beat(mk(LUI, 5'd4, 3'd0, 5'd0, 5'd0, 7'd0, 32'hABCDE000));
        send_beat(mk(RTYPE, 5'd5, 3'd0, 5'd1, 5'd2, 7'd0, 32'd0));
        @(negedge clk);
        do_start(14'h100);
        @(negedge clk);
        checks++;
        if (bus.imem_en !== 1'b0 || bus.count !== '0 || bus.err !== 1'b0) begin
            fails++;
            $display("FAIL start_flush: got en=%b count=%0d err=%b expected 0 0 0",
                     bus.imem_en, bus.count, bus.err);
        end
        rdy_mode = 1;
        drain("flush");
    endtask

    task automatic test_random();
        do_start(14'h0);
        rdy_mode = 2;
        for (int i = 0; i < 300; i++) begin
            send_beat(rand_beat());
            if ($urandom_range(0, 7) == 0) begin @(negedge clk); set_ready(); end
        end
        drain("random");
    endtask

    initial begin
        test_reset();
        test_addi();
        test_sequence();
        test_shift();
        test_error();
        test_stall();
        test_wrap_and_start();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
